// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller and the 4-bit ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LT  = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    localparam int REG_AW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU. Flags are only produced by ADD/SUB; every other
// function reports zero/overflow/carry as 0. LT is an unsigned compare.
// SUB carry is the carry-out of a + ~b + 1, i.e. 1 means "no borrow".
module alu_4bit
    import alu_pkg::*;
(
    input  logic [2:0] alu_fnselec,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    output logic [3:0] alu_res,
    output logic       alu_zero,
    output logic       alu_overflow,
    output logic       alu_carry
);

    logic [4:0] w_sum;

    // Function decode and flag generation.
    always_comb begin
        alu_res      = '0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        w_sum        = '0;
        case (alu_fnselec)
            ALU_ADD: begin
                w_sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res      = w_sum[3:0];
                alu_carry    = w_sum[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (w_sum[3] != alu_a[3]);
                alu_zero     = (w_sum[3:0] == 4'd0);
            end
            ALU_SUB: begin
                w_sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_res      = w_sum[3:0];
                alu_carry    = w_sum[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (w_sum[3] != alu_a[3]);
                alu_zero     = (w_sum[3:0] == 4'd0);
            end
            ALU_NOT: alu_res = ~alu_a;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_XOR: alu_res = alu_a ^ alu_b;
            ALU_LT:  alu_res = {3'b000, (alu_a < alu_b)};
            ALU_EQ:  alu_res = {3'b000, (alu_a == alu_b)};
            default: alu_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front-end for alu_4bit: accept an instruction, read operands
// from a 4x4 register file, execute for one cycle, write back and hold the
// result on a backpressured response channel.
//
// state | meaning
// IDLE  | ready for an instruction; operands latched on acceptance
// EXEC  | ALU driven from latched operands; writeback at the closing edge
// RESP  | response valid and held until rsp_ready
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int REG_COUNT = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_fn,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic              instr_imm_en,
    input  logic [3:0]        instr_imm,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [3:0]        rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [3:0]        rsp_res,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_carry,
    output logic              busy
);

    issue_state_t      r_state;
    issue_state_t      w_state_nxt;
    logic [2:0]        r_fn;
    logic [REG_AW-1:0] r_rd;
    logic [3:0]        r_a;
    logic [3:0]        r_b;
    logic [3:0]        r_regs [REG_COUNT];
    logic              w_accept;
    logic [3:0]        w_alu_res;
    logic              w_alu_zero;
    logic              w_alu_overflow;
    logic              w_alu_carry;

    assign w_accept    = instr_valid && (r_state == IDLE);
    assign instr_ready = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign busy        = (r_state != IDLE);
    assign rd_data     = r_regs[rd_addr];

    alu_4bit u_alu (
        .alu_fnselec  (r_fn),
        .alu_a        (r_a),
        .alu_b        (r_b),
        .alu_res      (w_alu_res),
        .alu_zero     (w_alu_zero),
        .alu_overflow (w_alu_overflow),
        .alu_carry    (w_alu_carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (instr_valid) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch at acceptance, using pre-edge register contents (no forwarding).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fn <= '0;
            r_rd <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_fn <= instr_fn;
            r_rd <= instr_rd;
            r_a  <= r_regs[instr_rs1];
            r_b  <= instr_imm_en ? instr_imm : r_regs[instr_rs2];
        end
    end

    // Register file: direct writes always honoured, ALU writeback wins on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else begin
            if (wr_en)             r_regs[wr_addr] <= wr_data;
            if (r_state == EXEC)   r_regs[r_rd]    <= w_alu_res;
        end
    end

    // Response capture at the end of EXEC; held until the next EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_res      <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_carry    <= 1'b0;
        end else if (r_state == EXEC) begin
            rsp_res      <= w_alu_res;
            rsp_zero     <= w_alu_zero;
            rsp_overflow <= w_alu_overflow;
            rsp_carry    <= w_alu_carry;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_fn;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic       instr_imm_en;
    logic [3:0] instr_imm;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_res;
    logic       rsp_zero;
    logic       rsp_overflow;
    logic       rsp_carry;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_ctrl #(.REG_COUNT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_fn     (instr_fn),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_res      (rsp_res),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_carry    (rsp_carry),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from arithmetic definitions: {res, zero, overflow, carry}.
    function automatic logic [6:0] alu_ref(input logic [2:0] fn, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r;
        logic [3:0] res;
        logic z, o, c;
        ua = int'(a); ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        res = 4'd0; z = 1'b0; o = 1'b0; c = 1'b0;
        case (fn)
            3'd0: begin
                r = ua + ub; res = 4'(r % 16); c = (r > 15);
                o = ((sa + sb) > 7) || ((sa + sb) < -8); z = (res == 4'd0);
            end
            3'd1: begin
                r = ua - ub + 16; res = 4'(r % 16); c = (ua >= ub);
                o = ((sa - sb) > 7) || ((sa - sb) < -8); z = (res == 4'd0);
            end
            3'd2: res = 4'(15 - ua);
            3'd3: res = a & b;
            3'd4: res = a | b;
            3'd5: res = a ^ b;
            3'd6: res = (ua < ub) ? 4'd1 : 4'd0;
            default: res = (ua == ub) ? 4'd1 : 4'd0;
        endcase
        return {res, z, o, c};
    endfunction

    // Transaction-level model: phase 0 idle, 1 executing, 2 responding.
    int         m_phase;
    logic [3:0] m_regs [4];
    logic [3:0] nregs  [4];
    logic [2:0] m_fn;
    logic [1:0] m_rd;
    logic [3:0] m_a, m_b;
    logic [3:0] m_res;
    logic       m_z, m_o, m_c;
    logic [6:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
            m_res = 4'd0; m_z = 1'b0; m_o = 1'b0; m_c = 1'b0;
        end else begin
            nregs = m_regs;
            if (wr_en) nregs[wr_addr] = wr_data;
            case (m_phase)
                0: if (instr_valid) begin
                    m_fn = instr_fn;
                    m_rd = instr_rd;
                    m_a  = m_regs[instr_rs1];
                    m_b  = instr_imm_en ? instr_imm : m_regs[instr_rs2];
                    m_phase = 1;
                end
                1: begin
                    m_out = alu_ref(m_fn, m_a, m_b);
                    {m_res, m_z, m_o, m_c} = m_out;
                    nregs[m_rd] = m_res;
                    m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
            m_regs = nregs;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("instr_ready", 8'(instr_ready), 8'(m_phase == 0));
            chk("busy",        8'(busy),        8'(m_phase != 0));
            chk("rsp_valid",   8'(rsp_valid),   8'(m_phase == 2));
            chk("rsp_res",     8'(rsp_res),     8'(m_res));
            chk("rsp_flags",   8'({rsp_zero, rsp_overflow, rsp_carry}), 8'({m_z, m_o, m_c}));
            chk("rd_data",     8'(rd_data),     8'(m_regs[rd_addr]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Offer one instruction in IDLE; returns after the EXEC closing edge.
    task automatic issue(input logic [2:0] fn, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ie, input logic [3:0] imm);
        instr_fn = fn; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_imm_en = ie; instr_imm = imm; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("lat_exec_valid", 8'(rsp_valid), 8'd0);
        chk("lat_exec_busy",  8'(busy),      8'd1);
        tick();
        chk("lat_resp_valid", 8'(rsp_valid), 8'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("back_to_idle", 8'(instr_ready), 8'd1);
    endtask

    task automatic peek(input string nm, input logic [1:0] a, input logic [3:0] exp);
        rd_addr = a;
        #1;
        chk(nm, 8'(rd_data), 8'(exp));
    endtask

    logic [3:0] held_res;

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_fn = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; instr_imm_en = 1'b0; instr_imm = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; rsp_ready = 1'b0;
        #23;
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_busy",      8'(busy),      8'd0);
        chk("rst_rsp_res",   8'(rsp_res),   8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_instr_ready", 8'(instr_ready), 8'd1);

        // 7 + 9 = 16: wraps to 0 with carry, zero set, no signed overflow.
        wr(2'd1, 4'd7);
        wr(2'd2, 4'd9);
        issue(3'b000, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0);
        chk("add_res", 8'(rsp_res), 8'h00);
        chk("add_zco", 8'({rsp_zero, rsp_carry, rsp_overflow}), 8'b110);
        peek("add_r3", 2'd3, 4'd0);
        release_rsp();

        // 5 - imm 3 = 2, no borrow.
        wr(2'd1, 4'd5);
        issue(3'b001, 2'd0, 2'd1, 2'd2, 1'b1, 4'd3);
        chk("sub_res", 8'(rsp_res), 8'h02);
        chk("sub_zco", 8'({rsp_zero, rsp_carry, rsp_overflow}), 8'b010);
        peek("sub_r0", 2'd0, 4'd2);
        release_rsp();

        // Compares: 3 < 5, and 5 == 5.
        wr(2'd0, 4'd3);
        issue(3'b110, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0);
        chk("lt_res", 8'(rsp_res), 8'h01);
        chk("lt_flags", 8'({rsp_zero, rsp_carry, rsp_overflow}), 8'b000);
        release_rsp();
        issue(3'b111, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0);
        chk("eq_res", 8'(rsp_res), 8'h01);
        release_rsp();

        // Back-pressure: 3 ^ A = 9, held while a second instruction is offered.
        issue(3'b101, 2'd3, 2'd0, 2'd0, 1'b1, 4'hA);
        held_res = rsp_res;
        chk("xor_res", 8'(rsp_res), 8'h09);
        instr_fn = 3'b000; instr_rd = 2'd1; instr_rs1 = 2'd0;
        instr_imm_en = 1'b1; instr_imm = 4'd1; instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 8'(rsp_valid),   8'd1);
            chk("bp_ready", 8'(instr_ready), 8'd0);
            chk("bp_res",   8'(rsp_res),     8'(held_res));
        end
        instr_valid = 1'b0;
        release_rsp();
        peek("bp_r1_untouched", 2'd1, 4'd5);

        // Collision on rd: ALU writeback (3 + 5 = 8) beats direct write of F.
        issue_collide(2'd2);
        chk("col_res", 8'(rsp_res), 8'h08);
        chk("col_ov",  8'({rsp_zero, rsp_carry, rsp_overflow}), 8'b001);
        peek("col_r2", 2'd2, 4'd8);
        release_rsp();
        // Collision-free: direct write to r1 and writeback to r2 both land.
        issue_collide(2'd1);
        peek("nocol_r1", 2'd1, 4'hF);
        peek("nocol_r2", 2'd2, 4'd8);
        release_rsp();

        // Reset in RESP drops everything at once.
        issue(3'b100, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(rsp_valid), 8'd0);
        chk("mid_rst_busy",  8'(busy),      8'd0);
        chk("mid_rst_res",   8'(rsp_res),   8'd0);
        for (int i = 0; i < 4; i++) peek("mid_rst_reg", 2'(i), 4'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wr(2'd1, 4'd2);
        wr(2'd2, 4'd3);
        issue(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0);
        chk("post_rst_res", 8'(rsp_res), 8'h05);
        peek("post_rst_r0", 2'd0, 4'd5);
        release_rsp();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ADD r2 = r0 + r1 with a direct write to waddr=F during EXEC.
    task automatic issue_collide(input logic [1:0] waddr);
        instr_fn = 3'b000; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
        instr_imm_en = 1'b0; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        wr_en = 1'b1; wr_addr = waddr; wr_data = 4'hF;
        tick();
        wr_en = 1'b0;
        chk("col_valid", 8'(rsp_valid), 8'd1);
    endtask

endmodule
